// File: rtl/comparator_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comparator_seq_ctrl
// Purpose  : Bit-serial equality/magnitude compare sequencer. Accepts one
//            operand pair per valid/ready handshake, walks the captured
//            operands MSB-first one bit per clock, then reports exactly one
//            of AeqB/AgtB/AltB together with a one-cycle done pulse and the
//            number of bit steps used.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand width in bits (>= 1)
//   SIGNED       0 = unsigned compare, 1 = two's-complement compare
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   start_valid  request: A/B are valid
//   start_ready  request can be accepted (IDLE only)
//   A, B         operands, sampled only on acceptance
//   busy         high in COMPARE and DONE
//   done         one-cycle pulse, results valid from this cycle on
//   AeqB/AgtB/AltB  compare result flags, held until the next completion
//   cycles       bit steps taken by the last compare
// Build option
//   COMPARE_EARLY_EXIT_EN  when defined, COMPARE ends on the first differing
//                          bit; otherwise every compare takes WIDTH steps.
// ============================================================================
module comparator_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic                       busy,
  output logic                       done,
  output logic                       AeqB,
  output logic                       AgtB,
  output logic                       AltB,
  output logic [$clog2(WIDTH+1)-1:0] cycles
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] c_MSB_IDX = IW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_COMPARE = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_nextState;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [IW-1:0]    r_idx;
  logic [CW-1:0]    r_step;
  logic             r_gt;
  logic             r_lt;
  logic             r_resEq;
  logic             r_resGt;
  logic             r_resLt;
  logic [CW-1:0]    r_cycles;

  logic w_accept;
  logic w_bitA;
  logic w_bitB;
  logic w_invert;
  logic w_bitGt;
  logic w_bitLt;
  logic w_decided;
  logic w_gt;
  logic w_lt;
  logic w_lastStep;
  logic w_exit;

  assign w_accept = start_valid & start_ready;

  // Current bit pair under examination.
  assign w_bitA = r_opA[r_idx];
  assign w_bitB = r_opB[r_idx];

  // In two's complement the sign bit carries negative weight, so a 1 in A's
  // MSB against a 0 in B's means A is the smaller value.
  assign w_invert = SIGNED && (r_idx == c_MSB_IDX);
  assign w_bitGt  = w_invert ? (~w_bitA &  w_bitB) : ( w_bitA & ~w_bitB);
  assign w_bitLt  = w_invert ? ( w_bitA & ~w_bitB) : (~w_bitA &  w_bitB);

  // Only the first differing bit may decide; later bits are ignored.
  assign w_decided  = r_gt | r_lt;
  assign w_gt       = r_gt | (~w_decided & w_bitGt);
  assign w_lt       = r_lt | (~w_decided & w_bitLt);
  assign w_lastStep = (r_idx == '0);

`ifdef COMPARE_EARLY_EXIT_EN
  assign w_exit = w_lastStep | (~w_decided & (w_bitGt | w_bitLt));
`else
  assign w_exit = w_lastStep;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:    if (w_accept) w_nextState = c_COMPARE;
      c_COMPARE: if (w_exit)   w_nextState = c_DONE;
      c_DONE:                  w_nextState = c_IDLE;
      default:                 w_nextState = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    start_ready = (r_state == c_IDLE);
    busy        = (r_state == c_COMPARE) || (r_state == c_DONE);
    done        = (r_state == c_DONE);
  end

  // Operand capture, bit walk and result registers. Results update only on
  // the edge that leaves COMPARE, so an aborting reset never publishes one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_idx    <= '0;
      r_step   <= '0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_resEq  <= 1'b0;
      r_resGt  <= 1'b0;
      r_resLt  <= 1'b0;
      r_cycles <= '0;
    end else if (w_accept) begin
      r_opA  <= A;
      r_opB  <= B;
      r_idx  <= c_MSB_IDX;
      r_step <= '0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
    end else if (r_state == c_COMPARE) begin
      r_idx  <= r_idx - IW'(1);
      r_step <= r_step + CW'(1);
      r_gt   <= w_gt;
      r_lt   <= w_lt;
      if (w_exit) begin
        r_resEq  <= ~w_gt & ~w_lt;
        r_resGt  <= w_gt;
        r_resLt  <= w_lt;
        r_cycles <= r_step + CW'(1);
      end
    end
  end

  assign AeqB   = r_resEq;
  assign AgtB   = r_resGt;
  assign AltB   = r_resLt;
  assign cycles = r_cycles;

endmodule
`default_nettype wire
